muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, setting the operand and result width.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MUL (low word), 01 MULH (high word), 10 DIV, 11 REM.
REQ-006 rs1_data  input  XLEN  operand A / dividend, taken from register file RD1.
REQ-007 rs2_data  input  XLEN  operand B / divisor, taken from register file RD2.
REQ-008 rd_addr  input  5  destination register index.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse marking result valid.
REQ-011 result  output  XLEN  operation result; drives register file WD3.
REQ-012 wb_addr  output  5  captured rd_addr; drives register file A3.
REQ-013 wb_we  output  1  write enable; drives register file WE3.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 In IDLE with start=1 at rising edge t, the block SHALL capture op, rs1_data, rs2_data and rd_addr, clear the iteration counter, and enter BUSY.
REQ-016 In BUSY, the block SHALL perform one iteration per cycle for exactly XLEN cycles (t+1..t+XLEN): shift-add for MUL/MULH, restoring shift-subtract for DIV/REM.
REQ-017 After the final iteration, the FSM SHALL enter DONE; done SHALL be high only in cycle t+XLEN+1, then return to IDLE.
REQ-018 Latency SHALL be fixed at XLEN+1 cycles for every op and operand value, including divide-by-zero.
REQ-019 busy SHALL be high in cycles t+1..t+XLEN and low in IDLE and DONE.
REQ-020 start in BUSY or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-021 result SHALL hold the last completed value until the next completion; wb_addr SHALL hold the captured rd_addr.
REQ-022 wb_we SHALL equal done AND (captured rd_addr != 0); a result destined for x0 SHALL never be written.
REQ-023 MUL SHALL return product bits [XLEN-1:0]; MULH SHALL return bits [2*XLEN-1:XLEN] of the full 2*XLEN product.
REQ-024 Divide by zero: DIV SHALL return all ones; REM SHALL return the dividend.
REQ-025 Input changes during BUSY SHALL NOT affect the result.

Reset
REQ-026 While reset is high, state SHALL be IDLE and busy, done, wb_we, result and wb_addr SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done or wb_we pulse; after release, the next start SHALL operate normally.

Configuration
REQ-028 Macro MULDIV_SIGNED_EN: when defined, operands SHALL be treated as two's complement, with MULH, DIV and REM giving RISC-V signed semantics.
REQ-029 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-030 With MULDIV_SIGNED_EN, overflow (most-negative / -1) SHALL return quotient equal to the most-negative value and remainder 0.
REQ-031 With MULDIV_SIGNED_EN, divide-by-zero SHALL return quotient -1 and remainder equal to the dividend.
REQ-032 Without MULDIV_SIGNED_EN, all operations SHALL be unsigned (MULHU/DIVU/REMU semantics), with no sign-correction logic present.
REQ-033 Latency SHALL be identical with and without the macro.

Structure
REQ-034 Package muldiv_pkg SHALL hold XLEN default, the op enum (OP_MUL, OP_MULH, OP_DIV, OP_REM) and the state enum.
REQ-035 One restoring-division iteration SHALL be a combinational sub-module div_step (inputs: partial remainder, divisor, next dividend bit; outputs: new remainder, quotient bit).
REQ-036 Multiplier iteration, counter and FSM SHALL reside in muldiv_unit.

Verification
REQ-037 MUL 7 x 6 (rd_addr=5) started at t -> done=1, result=42, wb_we=1, wb_addr=5 in cycle t+33; busy high t+1..t+32.
REQ-038 MULH 0xFFFFFFFF x 0xFFFFFFFF -> unsigned build: 0xFFFFFFFE; signed build: 0x00000000.
REQ-039 DIV 100/7 -> 14 and REM 100/7 -> 2; DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each exactly 33 cycles after start.
REQ-040 Signed build: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; DIV -7/2 -> -3; REM -7/2 -> -1.
REQ-041 Reset pulse at t+10 during MUL -> busy=0 immediately, with no done in cycles t+11..t+40; a new start afterwards completes correctly.
REQ-042 start re-asserted at t+5 with other operands -> ignored, first result unchanged; rd_addr=0 -> done=1 with wb_we=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
// Signed operation is enabled by defining MULDIV_SIGNED_EN at build time.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/writeback bundle of the multiply/divide unit.
// start is a request pulse taken only while idle; done is a one-cycle result-valid pulse.
interface muldiv_if #(parameter int XLEN = 32);
    import muldiv_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      wb_addr;
    logic            wb_we;
    state_e          dbg_state;

    modport master (
        output start, op, rs1_data, rs2_data, rd_addr,
        input  busy, done, result, wb_addr, wb_we, dbg_state
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_addr,
        output busy, done, result, wb_addr, wb_we, dbg_state
    );

endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            bit_in,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    assign shifted = {rem_in, bit_in};
    // When the subtraction succeeds the difference is below the divisor, so XLEN bits suffice.
    assign diff    = shifted[XLEN-1:0] - divisor;
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency (XLEN+1 cycle) shift-add multiplier / restoring divider.
// Define MULDIV_SIGNED_EN for two's-complement MULH/DIV/REM; default build is unsigned.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_rem;
    logic              div_q;
    logic [XLEN-1:0]   it_hi, it_lo;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   fin;

`ifdef MULDIV_SIGNED_EN
    logic neg_q, neg_d;
    logic rem_neg_q, rem_neg_d;

    // The datapath works on magnitudes; signs are restored on the final iteration.
    always_comb begin
        a_mag     = bus.rs1_data[XLEN-1] ? -bus.rs1_data : bus.rs1_data;
        b_mag     = bus.rs2_data[XLEN-1] ? -bus.rs2_data : bus.rs2_data;
        neg_d     = (bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1]) &&
                    !(is_div_op(op_e'(bus.op)) && (bus.rs2_data == '0));
        rem_neg_d = bus.rs1_data[XLEN-1];
    end
`else
    always_comb begin
        a_mag = bus.rs1_data;
        b_mag = bus.rs2_data;
    end
`endif

    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (hi_q),
        .divisor (b_q),
        .bit_in  (lo_q[XLEN-1]),
        .rem_out (div_rem),
        .q_bit   (div_q)
    );

    always_comb begin
        if (is_div_op(op_q)) begin
            it_hi = div_rem;
            it_lo = {lo_q[XLEN-2:0], div_q};
        end else begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = {it_hi, it_lo};
        quo  = it_lo;
        rem  = it_hi;
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
            prod = -{it_hi, it_lo};
            quo  = -it_lo;
        end
        if (rem_neg_q) begin
            rem = -it_hi;
        end
`endif
        case (op_q)
            OP_MUL:  fin = prod[XLEN-1:0];
            OP_MULH: fin = prod[2*XLEN-1:XLEN];
            OP_DIV:  fin = quo;
            default: fin = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        addr_d   = addr_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    b_d     = b_mag;
                    hi_d    = '0;
                    lo_d    = a_mag;
                    addr_d  = bus.rd_addr;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = fin;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            addr_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            addr_q   <= addr_d;
            result_q <= result_d;
        end
    end

`ifdef MULDIV_SIGNED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (state_q == ST_IDLE && bus.start) begin
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end
`endif

    assign bus.busy      = (state_q == ST_BUSY);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.wb_we     = bus.done && (addr_q != 5'd0);
    assign bus.result    = result_q;
    assign bus.wb_addr   = addr_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed known answers, random ops
// against a 64-bit arithmetic model, mid-operation reset and ignored starts.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [XLEN-1:0] exp_q[$];
  logic [4:0]      exp_addr_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
`ifdef MULDIV_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(sa * sb);
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
`else
    p = {32'd0, a} * {32'd0, b};
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return q;
      default: return r;
    endcase
  endfunction

  task automatic drive_idle();
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_addr  = '0;
  endtask

  // poke: re-assert start with other operands during BUSY and during DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit poke);
    int n;
    int busy_n;
    logic [XLEN-1:0] e;
    logic [4:0] ea;
    exp_q.push_back(exp);
    exp_addr_q.push_back(rd);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr  = rd;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.op       = 2'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_addr  = 5'($urandom);
    n = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      bus.start = (poke && n == 4);
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    e  = exp_q.pop_front();
    ea = exp_addr_q.pop_front();
    check_eq("latency", 64'(n), 64'd32);
    check_eq("busy_cycles", 64'(busy_n), 64'd32);
    check_eq("result", bus.result, e);
    check_eq("wb_addr", bus.wb_addr, ea);
    check_eq("wb_we", bus.wb_we, (ea != 5'd0));
    check_eq("busy_at_done", bus.busy, 1'b0);
    bus.start = poke;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_eq("done_pulse", bus.done, 1'b0);
    check_eq("idle_after", bus.busy, 1'b0);
    check_eq("result_hold", bus.result, e);
    if (poke) begin
      @(posedge clk);
      #1;
      check_eq("start_not_queued", bus.busy, 1'b0);
    end
  endtask

  task automatic reset_mid();
    int seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 2'b00;
    bus.rs1_data = 32'd7;
    bus.rs2_data = 32'd6;
    bus.rd_addr  = 5'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_result", bus.result, 32'd0);
    check_eq("rst_wb_addr", bus.wb_addr, 5'd0);
    check_eq("rst_state", bus.dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.wb_we === 1'b1) seen++;
    end
    check_eq("no_done_after_reset", 64'(seen), 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rrd;
    reset = 1'b1;
    drive_idle();
    #1;
    check_eq("init_busy", bus.busy, 1'b0);
    check_eq("init_wb_we", bus.wb_we, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("init_done", bus.done, 1'b0);
    check_eq("init_result", bus.result, 32'd0);
    check_eq("init_wb_addr", bus.wb_addr, 5'd0);
    check_eq("init_state", bus.dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 1'b0);
`else
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0);
`endif
    run_op(2'b10, 32'd100, 32'd7, 5'd2, 32'd14, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 5'd3, 32'd2, 1'b0);
    run_op(2'b10, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 5'd6, 32'd5, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0);
`endif
    run_op(2'b00, 32'd9, 32'd9, 5'd0, 32'd81, 1'b1);

    reset_mid();
    run_op(2'b00, 32'd123, 32'd456, 5'd11, 32'd56088, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 1) rb = 32'($urandom_range(1, 15));
      rrd = 5'($urandom_range(0, 31));
      run_op(rop, ra, rb, rrd, model(rop, ra, rb), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
